// File: rtl/decode_stage.sv
// RV32I instruction-decode pipeline stage with valid/ready handshake on both sides.
// A second holding entry absorbs one instruction under back-pressure so fetch sees a registered ready.
module decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter bit          EN_M_EXT = 1'b0,
    parameter bit          SKID     = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] instr_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [4:0]      out_rd_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [29:0]     out_ctrl_o,
    output logic            out_illegal_o
);

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] RF_PC4 = 2'b00;
    localparam logic [1:0] RF_MEM = 2'b10;
    localparam logic [1:0] RF_ALU = 2'b11;

    localparam logic [1:0] SRC_B_RS2 = 2'b00;
    localparam logic [1:0] SRC_B_IMM = 2'b01;
    localparam logic [1:0] SRC_B_PC  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_REL    = 2'b01;
    localparam logic [1:0] PC_RS1REL = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_COPY = 4'b1001;

    // 29 defined control bits; the MSB is reserved and always zero.
    typedef struct packed {
        logic       rsvd;
        logic [1:0] rf_sel;
        logic       src_a_sel;   // 0: rs1, 1: immediate (paired with SRC_B=PC for AUIPC)
        logic [1:0] src_b_sel;
        logic [3:0] alu_fun;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] byte_sel;
        logic       sign;
        logic [2:0] imm_sel;
        logic       branch;
        logic [2:0] br_type;
        logic       jump;
        logic [1:0] pc_sel;
        logic       md_valid;
        logic [2:0] md_fun;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      imm;
        ctrl_t                ctrl;
        logic                 illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      dec_ctrl;
    logic       dec_illegal;
    logic [31:0] imm32;
    bundle_t    dec_bundle;

    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_fire;
    logic    out_fire;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Control decode and legality check of the incoming instruction.
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_ctrl.rf_sel    = RF_ALU;
                dec_ctrl.src_b_sel = SRC_B_RS2;
                dec_ctrl.alu_fun   = {instr_i[30], funct3};
                dec_ctrl.reg_write = 1'b1;
                if (EN_M_EXT && (funct7 == F7_MULDIV)) begin
                    dec_ctrl.md_valid = 1'b1;
                    dec_ctrl.md_fun   = funct3;
                end else if (funct7 == F7_ALT) begin
                    if ((funct3 != 3'b000) && (funct3 != 3'b101)) begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct7 != F7_BASE) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_ctrl.rf_sel    = RF_ALU;
                dec_ctrl.src_b_sel = SRC_B_IMM;
                dec_ctrl.alu_fun   = {1'b0, funct3};
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.imm_sel   = IMM_I;
                if ((funct3 == 3'b001) && (funct7 != F7_BASE)) begin
                    dec_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_ctrl.alu_fun = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                dec_ctrl.rf_sel    = RF_MEM;
                dec_ctrl.src_b_sel = SRC_B_IMM;
                dec_ctrl.alu_fun   = ALU_ADD;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.byte_sel  = funct3[1:0];
                dec_ctrl.sign      = ~funct3[2];
                dec_ctrl.imm_sel   = IMM_I;
                if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                dec_ctrl.src_b_sel = SRC_B_IMM;
                dec_ctrl.alu_fun   = ALU_ADD;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.byte_sel  = funct3[1:0];
                dec_ctrl.imm_sel   = IMM_S;
                if (funct3 > 3'b010) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec_ctrl.src_b_sel = SRC_B_RS2;
                dec_ctrl.branch    = 1'b1;
                dec_ctrl.imm_sel   = IMM_B;
                dec_ctrl.pc_sel    = PC_REL;
                case (funct3)
                    3'b000:  dec_ctrl.br_type = 3'd0;
                    3'b001:  dec_ctrl.br_type = 3'd1;
                    3'b100:  dec_ctrl.br_type = 3'd2;
                    3'b101:  dec_ctrl.br_type = 3'd3;
                    3'b110:  dec_ctrl.br_type = 3'd4;
                    3'b111:  dec_ctrl.br_type = 3'd5;
                    default: dec_illegal      = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec_ctrl.rf_sel    = RF_PC4;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.imm_sel   = IMM_J;
                dec_ctrl.pc_sel    = PC_REL;
            end
            OPC_JALR: begin
                dec_ctrl.rf_sel    = RF_PC4;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.imm_sel   = IMM_I;
                dec_ctrl.pc_sel    = PC_RS1REL;
                if (funct3 != 3'b000) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_ctrl.rf_sel    = RF_ALU;
                dec_ctrl.src_b_sel = SRC_B_IMM;
                dec_ctrl.alu_fun   = ALU_COPY;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.imm_sel   = IMM_U;
            end
            OPC_AUIPC: begin
                dec_ctrl.rf_sel    = RF_ALU;
                dec_ctrl.src_a_sel = 1'b1;
                dec_ctrl.src_b_sel = SRC_B_PC;
                dec_ctrl.alu_fun   = ALU_ADD;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.imm_sel   = IMM_U;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (instr_i[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end

        // An illegal bundle still flows downstream but must not change architectural state.
        if (dec_illegal) begin
            dec_ctrl.reg_write = 1'b0;
            dec_ctrl.mem_write = 1'b0;
            dec_ctrl.mem_read  = 1'b0;
            dec_ctrl.branch    = 1'b0;
            dec_ctrl.jump      = 1'b0;
            dec_ctrl.md_valid  = 1'b0;
            dec_ctrl.pc_sel    = PC_PLUS4;
        end
    end

    // Immediate generation, sign bit is always instr_i[31].
    always_comb begin
        imm32 = '0;
        case (dec_ctrl.imm_sel)
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec_bundle         = '0;
        dec_bundle.pc      = instr_pc_i;
        dec_bundle.rs1     = instr_i[19:15];
        dec_bundle.rs2     = instr_i[24:20];
        dec_bundle.rd      = instr_i[11:7];
        dec_bundle.imm     = XLEN'($signed(imm32));
        dec_bundle.ctrl    = dec_ctrl;
        dec_bundle.illegal = dec_illegal;
    end

    // Ready never asserts during reset or flush so nothing is handshaken and then lost.
    assign in_ready_o = ~rst_i & ~flush_i &
                        (SKID ? ~skid_valid_q : (~main_valid_q | out_ready_i));
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = main_valid_q & out_ready_i;

    // MAIN drives the outputs; SKID only fills while MAIN is stalled.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (~main_valid_q | out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_d = dec_bundle;
                end
            end
        end else if (in_fire) begin
            skid_d       = dec_bundle;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid_o   = main_valid_q;
    assign out_pc_o      = main_q.pc;
    assign out_rs1_o     = main_q.rs1;
    assign out_rs2_o     = main_q.rs2;
    assign out_rd_o      = main_q.rd;
    assign out_imm_o     = main_q.imm;
    assign out_ctrl_o    = main_q.ctrl;
    assign out_illegal_o = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, back-pressure, flush and reset behaviour.
// A second instance with the M extension enabled shares the inputs.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic [29:0] out_ctrl;
    logic        out_illegal;

    logic        m_in_ready;
    logic        m_out_valid;
    logic [31:0] m_out_pc;
    logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
    logic [31:0] m_out_imm;
    logic [29:0] m_out_ctrl;
    logic        m_out_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_M_EXT(1'b0), .SKID(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .instr_pc_i(instr_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd),
        .out_imm_o(out_imm), .out_ctrl_o(out_ctrl), .out_illegal_o(out_illegal)
    );

    decode_stage #(.XLEN(32), .EN_M_EXT(1'b1), .SKID(1'b1)) dut_m (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(m_in_ready),
        .instr_i(instr), .instr_pc_i(instr_pc),
        .out_valid_o(m_out_valid), .out_ready_i(out_ready),
        .out_pc_o(m_out_pc), .out_rs1_o(m_out_rs1), .out_rs2_o(m_out_rs2), .out_rd_o(m_out_rd),
        .out_imm_o(m_out_imm), .out_ctrl_o(m_out_ctrl), .out_illegal_o(m_out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single cycle; returns #1 after the capturing edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        instr    = ins;
        instr_pc = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Field offsets within out_ctrl: rf_sel[28:27] src_b[25:24] alu[23:20] reg_write[19]
    // mem_write[18] mem_read[17] byte_sel[16:15] sign[14] imm_sel[13:11] branch[10]
    // br_type[9:7] jump[6] pc_sel[5:4] md_valid[3] md_fun[2:0]
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'h0; instr_pc = 32'h0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl",      32'(out_ctrl),  32'd0);
        chk("rst_imm",       out_imm,        32'd0);
        chk("rst_pc",        out_pc,         32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // ADDI x1, x0, 5
        send(32'h00500093, 32'h0000_0010);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_pc",    out_pc,         32'h10);
        chk("addi_rd",    32'(out_rd),    32'd1);
        chk("addi_imm",   out_imm,        32'd5);
        chk("addi_ctrl",  32'(out_ctrl),
            32'({1'b0, 2'b11, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0,
                 3'b000, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 3'b000}));

        // SUB x3, x1, x2
        send(32'h402081B3, 32'h0000_0014);
        chk("sub_rs1", 32'(out_rs1), 32'd1);
        chk("sub_rs2", 32'(out_rs2), 32'd2);
        chk("sub_rd",  32'(out_rd),  32'd3);
        chk("sub_alu", 32'(out_ctrl[23:20]), 32'h8);
        chk("sub_ill", 32'(out_illegal), 32'd0);

        // MUL x3, x1, x2 on both instances
        send(32'h022081B3, 32'h0000_0018);
        chk("mul_noM_illegal", 32'(out_illegal),      32'd1);
        chk("mul_noM_regwr",   32'(out_ctrl[19]),     32'd0);
        chk("mul_M_illegal",   32'(m_out_illegal),    32'd0);
        chk("mul_M_mdvalid",   32'(m_out_ctrl[3]),    32'd1);
        chk("mul_M_mdfun",     32'(m_out_ctrl[2:0]),  32'd0);
        chk("mul_M_regwr",     32'(m_out_ctrl[19]),   32'd1);
        chk("mul_M_rfsel",     32'(m_out_ctrl[28:27]), 32'd3);

        // BEQ x0, x0, -4
        send(32'hFE000EE3, 32'h0000_001C);
        chk("beq_imm",    out_imm,                 32'hFFFF_FFFC);
        chk("beq_brtype", 32'(out_ctrl[9:7]),      32'd0);
        chk("beq_branch", 32'(out_ctrl[10]),       32'd1);
        chk("beq_pcsel",  32'(out_ctrl[5:4]),      32'd1);
        chk("beq_immsel", 32'(out_ctrl[13:11]),    32'd2);

        // JAL x0, +8
        send(32'h0080006F, 32'h0000_0020);
        chk("jal_imm",   out_imm,             32'd8);
        chk("jal_jump",  32'(out_ctrl[6]),    32'd1);
        chk("jal_pcsel", 32'(out_ctrl[5:4]),  32'd1);
        chk("jal_rfsel", 32'(out_ctrl[28:27]), 32'd0);

        // LBU x1, 0(x1)
        send(32'h0000C083, 32'h0000_0024);
        chk("lbu_memrd", 32'(out_ctrl[17]),    32'd1);
        chk("lbu_sign",  32'(out_ctrl[14]),    32'd0);
        chk("lbu_rfsel", 32'(out_ctrl[28:27]), 32'd2);

        // Load with funct3=011 is illegal
        send(32'h0000B083, 32'h0000_0028);
        chk("ld011_illegal", 32'(out_illegal),  32'd1);
        chk("ld011_memrd",   32'(out_ctrl[17]), 32'd0);
        chk("ld011_regwr",   32'(out_ctrl[19]), 32'd0);

        // SW x2, 4(x1)
        send(32'h0020A223, 32'h0000_002C);
        chk("sw_imm",     out_imm,              32'd4);
        chk("sw_memwr",   32'(out_ctrl[18]),    32'd1);
        chk("sw_bytesel", 32'(out_ctrl[16:15]), 32'd2);

        // SRAI x1, x1, 3 and SLLI with funct7=0100000
        send(32'h4030D093, 32'h0000_0030);
        chk("srai_alu", 32'(out_ctrl[23:20]), 32'hD);
        chk("srai_ill", 32'(out_illegal),     32'd0);
        send(32'h40309093, 32'h0000_0034);
        chk("slli_bad_ill", 32'(out_illegal), 32'd1);

        // LUI x5, 0x12345
        send(32'h123452B7, 32'h0000_0038);
        chk("lui_imm", out_imm,              32'h1234_5000);
        chk("lui_alu", 32'(out_ctrl[23:20]), 32'h9);
        chk("lui_rd",  32'(out_rd),          32'd5);

        // JALR with funct3=001 is illegal: jump and pc_sel cleared
        send(32'h000110E7, 32'h0000_003C);
        chk("jalr_bad_ill",   32'(out_illegal),    32'd1);
        chk("jalr_bad_jump",  32'(out_ctrl[6]),    32'd0);
        chk("jalr_bad_pcsel", 32'(out_ctrl[5:4]),  32'd0);

        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure: OUT_READY low for three cycles while four instructions arrive
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00500093; instr_pc = 32'h100;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'd1);
        step();
        chk("bp_out_a0", out_pc, 32'h100);
        instr_pc = 32'h104;
        #1;
        chk("bp_ready1", 32'(in_ready), 32'd1);
        step();
        instr_pc = 32'h108;
        #1;
        chk("bp_ready2", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b1;
        chk("bp_ready3",  32'(in_ready),  32'd0);
        chk("bp_out_a",   out_pc,         32'h100);
        chk("bp_valid_a", 32'(out_valid), 32'd1);
        step();
        chk("bp_out_b",   out_pc,         32'h104);
        chk("bp_valid_b", 32'(out_valid), 32'd1);
        chk("bp_ready4",  32'(in_ready),  32'd1);
        step();
        chk("bp_out_c",   out_pc,         32'h108);
        chk("bp_valid_c", 32'(out_valid), 32'd1);
        instr_pc = 32'h10C;
        step();
        in_valid = 1'b0;
        chk("bp_out_d",   out_pc,         32'h10C);
        chk("bp_valid_d", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty",   32'(out_valid), 32'd0);

        // Flush with both entries full and an input offered
        out_ready = 1'b0;
        send(32'h00500093, 32'h200);
        send(32'h00500093, 32'h204);
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        chk("fl_full_pc",    out_pc,        32'h200);
        flush = 1'b1; in_valid = 1'b1; instr_pc = 32'h208;
        #1;
        chk("fl_ready_during", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid_after", 32'(out_valid), 32'd0);
        #1;
        chk("fl_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_dropped", 32'(out_valid), 32'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'h0080006F, 32'h300);
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; in_valid = 1'b1; instr = 32'h00500093; instr_pc = 32'h304;
        step();
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_pc",    out_pc,         32'd0);
        chk("mr_ctrl",  32'(out_ctrl),  32'd0);
        chk("mr_imm",   out_imm,        32'd0);
        chk("mr_rd",    32'(out_rd),    32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("mr_ready", 32'(in_ready), 32'd1);
        send(32'h00000000, 32'h400);
        chk("zero_valid",   32'(out_valid),    32'd1);
        chk("zero_illegal", 32'(out_illegal),  32'd1);
        chk("zero_regwr",   32'(out_ctrl[19]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
